ws2811_frame_sequencer: RTL and testbench

Sequences the per-LED colour datapath (`ledcontroller`) across a whole strip, one frame at a time. It freezes the mode and animation inputs at frame start, then walks `ledindex` from 0 to NUM_LEDS-1. For each LED it captures the registered RGB result and hands a 24-bit pixel to the WS2811 bit serializer over a valid/ready handshake. After the last pixel drains, it times the WS2811 latch gap and pulses `frame_done`.

---
 rtl/ws2811_pkg.sv | 43 ++++
 rtl/gap_timer.sv | 52 +++++
 rtl/ws2811_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ws2811_frame_sequencer.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2811_pkg.sv
// Shared types and constants for the WS2811 frame sequencer and its bit serializer.
// Both blocks import this package so pixel width and colour order stay in one place.
package ws2811_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT1 = 3'd1,
        ST_WAIT2 = 3'd2,
        ST_SEND  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_LATCH = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        ORDER_RGB = 2'd0,
        ORDER_GRB = 2'd1,
        ORDER_BRG = 2'd2
    } colour_order_e;

    localparam int unsigned   PIXEL_W              = 24;
    localparam int unsigned   GAP_W                = 16;
    localparam colour_order_e COLOUR_ORDER         = ORDER_RGB;
    localparam int unsigned   DEFAULT_NUM_LEDS     = 50;
    localparam int unsigned   DEFAULT_LATCH_CYCLES = 2500;

    // The first colour in the returned word is shifted out first by the serializer.
    function automatic logic [PIXEL_W-1:0] pack_pixel(
        input colour_order_e order,
        input logic [7:0]    r,
        input logic [7:0]    g,
        input logic [7:0]    b
    );
        logic [PIXEL_W-1:0] px;
        case (order)
            ORDER_RGB: px = {r, g, b};
            ORDER_GRB: px = {g, r, b};
            ORDER_BRG: px = {b, r, g};
            default:   px = {r, g, b};
        endcase
        return px;
    endfunction

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter with a registered expiry flag; shared by the frame latch gap
// and the serializer's bit timing.
module gap_timer
    import ws2811_pkg::*;
#(
    parameter int unsigned WIDTH = GAP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             done_q;
    logic             done_d;

    // Next count: a load wins over a tick; the count saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (tick && (count_q != ZERO)) begin
            count_d = count_q - ONE;
        end else begin
            count_d = count_q;
        end
        done_d = (count_d == ZERO);
    end

    // Counter and expiry flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ZERO;
            done_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// Walks ledindex across the strip once per frame, hands each ledcontroller result to the
// serializer over valid/ready, then times the WS2811 latch gap and pulses frame_done.
module ws2811_frame_sequencer
    import ws2811_pkg::*;
#(
    parameter int unsigned NUM_LEDS     = DEFAULT_NUM_LEDS,
    parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [7:0]         mode_in,
    input  logic [7:0]         animationcounter_in,
    input  logic [7:0]         stepclock_in,
    output logic [7:0]         mode,
    output logic [7:0]         animationcounter,
    output logic [7:0]         stepclock,
    output logic [7:0]         ledindex,
    input  logic [7:0]         red,
    input  logic [7:0]         green,
    input  logic [7:0]         blue,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    input  logic               tx_idle,
    output logic               busy,
    output logic               frame_done
);

    localparam logic [7:0]       LAST_IDX   = 8'(NUM_LEDS - 32'd1);
    localparam logic [GAP_W-1:0] LATCH_LOAD = GAP_W'(LATCH_CYCLES - 32'd1);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(32'd1);
    localparam logic             ONE_CYCLE_LATCH = (LATCH_CYCLES == 32'd1);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [7:0]         ledindex_q;
    logic [7:0]         ledindex_d;
    logic [7:0]         mode_q;
    logic [7:0]         mode_d;
    logic [7:0]         anim_q;
    logic [7:0]         anim_d;
    logic [7:0]         step_q;
    logic [7:0]         step_d;
    logic [PIXEL_W-1:0] pixel_data_q;
    logic [PIXEL_W-1:0] pixel_data_d;
    logic               pixel_valid_q;
    logic               pixel_valid_d;
    logic               frame_done_q;
    logic               frame_done_d;

    logic               timer_load_s;
    logic               timer_tick_s;
    logic [GAP_W-1:0]   timer_count_s;
    logic               timer_done_s;

    gap_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load_s),
        .load_value (LATCH_LOAD),
        .tick       (timer_tick_s),
        .count      (timer_count_s),
        .done       (timer_done_s)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        ledindex_d    = ledindex_q;
        mode_d        = mode_q;
        anim_d        = anim_q;
        step_d        = step_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = pixel_valid_q;
        frame_done_d  = 1'b0;
        timer_load_s  = 1'b0;
        timer_tick_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    mode_d     = mode_in;
                    anim_d     = animationcounter_in;
                    step_d     = stepclock_in;
                    ledindex_d = 8'd0;
                    state_d    = ST_WAIT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // One cycle for ledcontroller to register the colour of the new index.
            ST_WAIT1: begin
                state_d = ST_WAIT2;
            end

            ST_WAIT2: begin
                pixel_data_d  = pack_pixel(COLOUR_ORDER, red, green, blue);
                pixel_valid_d = 1'b1;
                state_d       = ST_SEND;
            end

            ST_SEND: begin
                if (pixel_valid_q && pixel_ready) begin
                    pixel_valid_d = 1'b0;
                    if (ledindex_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        ledindex_d = ledindex_q + 8'd1;
                        state_d    = ST_WAIT1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            ST_DRAIN: begin
                if (tx_idle) begin
                    timer_load_s = 1'b1;
                    frame_done_d = ONE_CYCLE_LATCH;
                    state_d      = ST_LATCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            // frame_done is raised on the edge that enters the final gap cycle.
            ST_LATCH: begin
                timer_tick_s = 1'b1;
                if (timer_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    frame_done_d = (timer_count_s == GAP_ONE);
                    state_d      = ST_LATCH;
                end
            end

            default: begin
                pixel_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ledindex_q    <= 8'd0;
            mode_q        <= 8'd0;
            anim_q        <= 8'd0;
            step_q        <= 8'd0;
            pixel_data_q  <= {PIXEL_W{1'b0}};
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ledindex_q    <= ledindex_d;
            mode_q        <= mode_d;
            anim_q        <= anim_d;
            step_q        <= step_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign mode             = mode_q;
    assign animationcounter = anim_q;
    assign stepclock        = step_q;
    assign ledindex         = ledindex_q;
    assign pixel_data       = pixel_data_q;
    assign pixel_valid      = pixel_valid_q;
    assign frame_done       = frame_done_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Bench for ws2811_frame_sequencer: a queue of expected pixels and frozen inputs, pushed when
// a frame is started and popped on each accepted pixel, plus per-scenario timing tasks.
`timescale 1ns/1ps
module tb_ws2811_frame_sequencer;

    localparam int unsigned N_A = 4;
    localparam int unsigned L_A = 5;
    localparam int unsigned N_B = 1;
    localparam int unsigned L_B = 3;

    typedef struct packed {
        logic [23:0] pix;
        logic [7:0]  idx;
        logic [7:0]  mode;
        logic [7:0]  anim;
        logic [7:0]  step;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;
    int fd_count = 0;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [7:0]  mode_in = 8'd0;
    logic [7:0]  anim_in = 8'd0;
    logic [7:0]  step_in = 8'd0;
    logic        pixel_ready = 1'b0;
    logic        tx_idle     = 1'b0;

    logic [7:0]  mode, anim, step, ledindex;
    logic [7:0]  red, green, blue;
    logic [23:0] pixel_data;
    logic        pixel_valid, busy, frame_done;

    logic        en2    = 1'b0;
    logic        ready2 = 1'b1;
    logic        tx2    = 1'b0;
    logic [7:0]  mode2, anim2, step2, ledindex2;
    logic [7:0]  red2, green2, blue2;
    logic [23:0] data2;
    logic        valid2, busy2, fd2;

    ws2811_frame_sequencer #(.NUM_LEDS(N_A), .LATCH_CYCLES(L_A)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mode_in(mode_in), .animationcounter_in(anim_in), .stepclock_in(step_in),
        .mode(mode), .animationcounter(anim), .stepclock(step), .ledindex(ledindex),
        .red(red), .green(green), .blue(blue),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .tx_idle(tx_idle), .busy(busy), .frame_done(frame_done)
    );

    ws2811_frame_sequencer #(.NUM_LEDS(N_B), .LATCH_CYCLES(L_B)) dut_one (
        .clk(clk), .reset(reset), .enable(en2),
        .mode_in(mode_in), .animationcounter_in(anim_in), .stepclock_in(step_in),
        .mode(mode2), .animationcounter(anim2), .stepclock(step2), .ledindex(ledindex2),
        .red(red2), .green(green2), .blue(blue2),
        .pixel_data(data2), .pixel_valid(valid2), .pixel_ready(ready2),
        .tx_idle(tx2), .busy(busy2), .frame_done(fd2)
    );

    always #5 clk = ~clk;

    // Stand-in for ledcontroller: mode 0 walks a 4-colour palette, other modes mix the inputs.
    function automatic logic [23:0] led_model(input logic [7:0] m, input logic [7:0] a,
                                              input logic [7:0] s, input logic [7:0] idx);
        logic [7:0]  sel;
        logic [23:0] c;
        sel = idx + s;
        if (m == 8'd0) begin
            case (sel[1:0])
                2'd0:    c = 24'hFF0000;
                2'd1:    c = 24'h00FF00;
                2'd2:    c = 24'h0000FF;
                default: c = 24'hFFFF00;
            endcase
        end else begin
            c = {idx ^ a, m, sel};
        end
        return c;
    endfunction

    always @(posedge clk) {red, green, blue} <= led_model(mode, anim, step, ledindex);
    always @(posedge clk) {red2, green2, blue2} <= led_model(mode2, anim2, step2, ledindex2);

    // Scoreboard consumer and stability monitor on the falling edge.
    initial begin : monitor
        logic        hold_prev;
        logic [23:0] data_prev;
        exp_t        e;
        hold_prev = 1'b0;
        data_prev = 24'd0;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_count++;
            if (hold_prev) begin
                checks++;
                if (pixel_valid !== 1'b1 || pixel_data !== data_prev) begin
                    failures++;
                    $display("FAIL hold_stable got valid=%b data=%h exp valid=1 data=%h",
                             pixel_valid, pixel_data, data_prev);
                end
            end
            hold_prev = (pixel_valid === 1'b1) && (pixel_ready === 1'b0) && (reset === 1'b0);
            data_prev = pixel_data;
            if (pixel_valid === 1'b1 && pixel_ready === 1'b1 && reset === 1'b0) begin
                accepts++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got pixel=%h idx=%0d exp no pixel", pixel_data, ledindex);
                end else begin
                    e = sb_q.pop_front();
                    if (pixel_data !== e.pix) begin
                        failures++;
                        $display("FAIL sb_pixel got=%h exp=%h (idx %0d)", pixel_data, e.pix, e.idx);
                    end
                    checks++;
                    if (ledindex !== e.idx) begin
                        failures++;
                        $display("FAIL sb_ledindex got=%0d exp=%0d", ledindex, e.idx);
                    end
                    checks++;
                    if ({mode, anim, step} !== {e.mode, e.anim, e.step}) begin
                        failures++;
                        $display("FAIL sb_frozen got=%h exp=%h", {mode, anim, step},
                                 {e.mode, e.anim, e.step});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_frame();
        for (int i = 0; i < int'(N_A); i++) begin
            sb_q.push_back('{pix: led_model(mode_in, anim_in, step_in, 8'(i)), idx: 8'(i),
                             mode: mode_in, anim: anim_in, step: step_in});
        end
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        enable = 1'b1;
        push_frame();
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_idx(input logic [7:0] idx, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ledindex === idx) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (pixel_valid === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_fd(input int limit, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cyc++;
            if (frame_done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ledindex, mode, anim, step, pixel_data, pixel_valid, busy, frame_done} !== 59'd0) begin
            failures++;
            $display("FAIL reset_outputs got idx=%h mode=%h data=%h valid=%b busy=%b fd=%b exp all 0",
                     ledindex, mode, pixel_data, pixel_valid, busy, frame_done);
        end
        checks++;
        if ({ledindex2, mode2, data2, valid2, busy2, fd2} !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs_one got idx=%h data=%h valid=%b busy=%b exp all 0",
                     ledindex2, data2, valid2, busy2);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        bit ok;
        int cyc;
        logic [3:0] seen;
        mode_in = 8'd0; anim_in = 8'd0; step_in = 8'd0;
        pixel_ready = 1'b1; tx_idle = 1'b0;
        start_frame();
        // Negedges after e0 .. e0+5: valid pattern 0,0,1,0,0,1 with ledindex 0,0,0,1,1,1.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = {busy, pixel_valid, ledindex[1:0]};
            checks++;
            if (seen !== {1'b1, (k == 2 || k == 5), (k >= 3) ? 2'd1 : 2'd0}) begin
                failures++;
                $display("FAIL first_pixel_timing k=%0d got busy/valid/idx=%b exp=%b", k, seen,
                         {1'b1, (k == 2 || k == 5), (k >= 3) ? 2'd1 : 2'd0});
            end
        end
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || pixel_valid !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL drain_hold got busy=%b valid=%b fd=%b exp 1 0 0", busy, pixel_valid, frame_done);
        end
        @(posedge clk); #1;
        tx_idle = 1'b1;
        wait_fd(50, ok, cyc);
        checks++;
        if (!ok || cyc != int'(L_A) + 1) begin
            failures++;
            $display("FAIL latch_gap got cycles=%0d ok=%b exp cycles=%0d", cyc, ok, L_A + 1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_frame got busy=%b fd=%b exp 0 0", busy, frame_done);
        end
        checks++;
        if (fd_count != 1 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL basic_count got frames=%0d left=%0d exp frames=1 left=0", fd_count, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        int acc0;
        logic [23:0] exp_px;
        mode_in = 8'd0; anim_in = 8'd0; step_in = 8'd1;
        pixel_ready = 1'b1; tx_idle = 1'b1;
        exp_px = led_model(8'd0, 8'd0, 8'd1, 8'd2);
        acc0 = accepts;
        start_frame();
        wait_idx(8'd2, 40, ok);
        @(posedge clk); #1;
        pixel_ready = 1'b0;
        wait_valid(5, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_valid_rise got valid=%b exp 1", pixel_valid);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (pixel_valid !== 1'b1 || pixel_data !== exp_px || ledindex !== 8'd2) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got valid=%b data=%h idx=%0d exp 1 %h 2",
                         i, pixel_valid, pixel_data, ledindex, exp_px);
            end
        end
        @(posedge clk); #1;
        pixel_ready = 1'b1;
        wait_fd(200, ok, cyc);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || accepts - acc0 != int'(N_A) || sb_q.size() != 0) begin
            failures++;
            $display("FAIL bp_accepts got=%0d done=%b exp=%0d done=1", accepts - acc0, ok, N_A);
        end
    endtask

    task automatic test_freeze();
        bit ok;
        int cyc;
        mode_in = 8'd0; anim_in = 8'h10; step_in = 8'd0;
        pixel_ready = 1'b1; tx_idle = 1'b1;
        start_frame();
        wait_idx(8'd1, 40, ok);
        @(posedge clk); #1;
        mode_in = 8'd1; step_in = 8'd1; anim_in = 8'h77;
        @(negedge clk);
        checks++;
        if ({mode, anim, step} !== {8'd0, 8'h10, 8'd0}) begin
            failures++;
            $display("FAIL freeze_mid got=%h exp=%h", {mode, anim, step}, {8'd0, 8'h10, 8'd0});
        end
        wait_fd(200, ok, cyc);
        @(negedge clk);
        checks++;
        if (!ok || {mode, anim, step} !== {8'd0, 8'h10, 8'd0}) begin
            failures++;
            $display("FAIL freeze_idle got=%h done=%b exp=%h", {mode, anim, step}, ok, {8'd0, 8'h10, 8'd0});
        end
        start_frame();
        @(negedge clk);
        checks++;
        if ({mode, anim, step} !== {8'd1, 8'h77, 8'd1}) begin
            failures++;
            $display("FAIL freeze_new_snapshot got=%h exp=%h", {mode, anim, step}, {8'd1, 8'h77, 8'd1});
        end
        wait_fd(200, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL freeze_second_frame got done=0 exp done=1");
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int cyc;
        mode_in = 8'd7; anim_in = 8'h11; step_in = 8'd2;
        pixel_ready = 1'b1; tx_idle = 1'b1;
        start_frame();
        wait_idx(8'd3, 60, ok);
        @(posedge clk); #1;
        pixel_ready = 1'b0;
        wait_valid(5, ok);
        checks++;
        if (!ok || ledindex !== 8'd3) begin
            failures++;
            $display("FAIL rst_setup got valid=%b idx=%0d exp 1 3", pixel_valid, ledindex);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ledindex, mode, anim, step, pixel_data, pixel_valid, busy, frame_done} !== 59'd0) begin
            failures++;
            $display("FAIL rst_midframe got idx=%h mode=%h data=%h valid=%b busy=%b exp all 0",
                     ledindex, mode, pixel_data, pixel_valid, busy);
        end
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        pixel_ready = 1'b1;
        start_frame();
        @(negedge clk);
        checks++;
        if (ledindex !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart got idx=%0d busy=%b exp 0 1", ledindex, busy);
        end
        wait_fd(200, ok, cyc);
        checks++;
        if (!ok || sb_q.size() != 0) begin
            failures++;
            $display("FAIL rst_restart_frame got done=%b left=%0d exp 1 0", ok, sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        int fd0;
        mode_in = 8'd2; anim_in = 8'h5A; step_in = 8'd3;
        pixel_ready = 1'b1; tx_idle = 1'b1;
        repeat (2) @(negedge clk);
        fd0 = fd_count;
        @(posedge clk); #1;
        enable = 1'b1;
        push_frame();
        wait_fd(200, ok, cyc);
        push_frame();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ledindex !== 8'(N_A - 1)) begin
            failures++;
            $display("FAIL b2b_idle_cycle got busy=%b idx=%0d exp 0 %0d", busy, ledindex, N_A - 1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ledindex !== 8'd0) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b idx=%0d exp 1 0", busy, ledindex);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        enable = 1'b0;
        wait_fd(200, ok, cyc);
        repeat (40) @(negedge clk);
        checks++;
        if (!ok || fd_count - fd0 != 2 || busy !== 1'b0 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_stop got frames=%0d busy=%b left=%0d exp frames=2 busy=0 left=0",
                     fd_count - fd0, busy, sb_q.size());
        end
    endtask

    task automatic test_single_led();
        bit ok;
        int cyc;
        int extra_valid;
        int not_busy;
        int bad_idx;
        int early_fd;
        mode_in = 8'd0; anim_in = 8'd0; step_in = 8'd0;
        ready2 = 1'b1; tx2 = 1'b0;
        @(posedge clk); #1;
        en2 = 1'b1;
        @(posedge clk); #1;
        en2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid2 === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || data2 !== 24'hFF0000 || ledindex2 !== 8'd0) begin
            failures++;
            $display("FAIL one_pixel got valid=%b data=%h idx=%0d exp 1 ff0000 0", ok, data2, ledindex2);
        end
        extra_valid = 0; not_busy = 0; bad_idx = 0; early_fd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid2 === 1'b1) extra_valid++;
            if (busy2 !== 1'b1) not_busy++;
            if (ledindex2 !== 8'd0) bad_idx++;
            if (fd2 === 1'b1) early_fd++;
        end
        checks++;
        if (extra_valid != 0 || not_busy != 0 || bad_idx != 0 || early_fd != 0) begin
            failures++;
            $display("FAIL one_drain got valid=%0d idle=%0d badidx=%0d fd=%0d exp all 0",
                     extra_valid, not_busy, bad_idx, early_fd);
        end
        @(posedge clk); #1;
        tx2 = 1'b1;
        ok = 1'b0; cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cyc++;
            if (fd2 === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || cyc != int'(L_B) + 1) begin
            failures++;
            $display("FAIL one_latch_gap got cycles=%0d ok=%b exp cycles=%0d", cyc, ok, L_B + 1);
        end
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b0 || fd2 !== 1'b0) begin
            failures++;
            $display("FAIL one_idle got busy=%b fd=%b exp 0 0", busy2, fd2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_freeze();
        test_reset_midframe();
        test_back_to_back();
        test_single_led();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
